// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the sequential square-root unit.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int rw_of(input int width);
    return width / 2;
  endfunction

  function automatic int cnt_w(input int rw);
    return (rw > 1) ? $clog2(rw) : 1;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: consumes two radicand bits, yields one root bit.
module sqrt_step #(
  parameter int RW = 4
) (
  input  logic [RW-1:0] i_q,
  input  logic [RW:0]   i_r,
  input  logic [1:0]    i_bits,
  output logic [RW-1:0] o_q,
  output logic [RW:0]   o_r
);

  logic [RW+2:0] w_rp, w_sub, w_t;
  logic          w_neg;
  logic          w_unused;

  assign w_rp  = {i_r, i_bits};
  assign w_sub = {1'b0, i_q, 2'b01};
  assign w_t   = w_rp - w_sub;
  // Top bit acts as the sign: R' stays below 2^(RW+2), so it never carries real magnitude.
  assign w_neg = w_t[RW+2];

  // The partial root shifts left once per step, so its MSB is always zero on entry.
  assign w_unused = ^{i_q[RW-1], w_t[RW+1]};

  always_comb begin
    o_q = {i_q[RW-2:0], ~w_neg};
    o_r = w_neg ? w_rp[RW:0] : w_t[RW:0];
  end

endmodule

// File: rtl/sqrt_seq_unit.sv
// Sequential floor(sqrt(D)), two radicand bits per cycle, start/busy/done handshake.
// Define SQRT_REMAINDER_EN to add the registered remainder output.
module sqrt_seq_unit
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       radicand,
  output logic                   busy,
  output logic                   done,
  output logic [rw_of(WIDTH)-1:0] root
`ifdef SQRT_REMAINDER_EN
  ,
  output logic [rw_of(WIDTH):0]  remainder
`endif
);

  localparam int RW = rw_of(WIDTH);
  localparam int CW = cnt_w(RW);

  state_t           r_state, w_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d;
  logic [RW-1:0]    r_q, r_root;
  logic [RW:0]      r_r;
  logic [RW-1:0]    w_qn;
  logic [RW:0]      w_rn;
  logic             w_last;

  sqrt_step #(.RW(RW)) u_step (
    .i_q    (r_q),
    .i_r    (r_r),
    .i_bits (r_d[WIDTH-1:WIDTH-2]),
    .o_q    (w_qn),
    .o_r    (w_rn)
  );

  assign w_last = (r_cnt == CW'(RW-1));

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_nxt = CALC;
      CALC:    if (w_last) w_nxt = DONE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_d     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_root  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && start) begin
        r_d   <= radicand;
        r_q   <= '0;
        r_r   <= '0;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_d   <= {r_d[WIDTH-3:0], 2'b00};
        r_q   <= w_qn;
        r_r   <= w_rn;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_root <= w_qn;
      end
    end
  end

`ifdef SQRT_REMAINDER_EN
  logic [RW:0] r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_rem <= '0;
    else if (r_state == CALC && w_last) r_rem <= w_rn;
  end

  assign remainder = r_rem;
`endif

  assign root = r_root;
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

endmodule
